// File: rtl/mem_burst_ctrl.sv
// Burst controller for a single mem_sram bank: turns line-granular read/write burst requests
// into per-line sram strobes, with one-cycle read return and done/err status pulses.
module mem_burst_ctrl #(
  parameter logic [3:0] BANK_ID = 4'd0
) (
  input  logic         clk,
  input  logic         rst_n,

  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_write,
  input  logic [18:0]  req_addr,
  input  logic [4:0]   req_len,

  input  logic [255:0] wr_data,
  input  logic         wr_valid,
  output logic         wr_ready,

  output logic [255:0] rd_data,
  output logic         rd_valid,

  output logic         done,
  output logic         err,

  output logic         sram_cs,
  output logic         sram_read,
  output logic         sram_write,
  output logic [18:0]  sram_addr,
  output logic [3:0]   sram_id,
  output logic [255:0] sram_wdata,
  input  logic [255:0] sram_rdata
);

  typedef enum logic [1:0] {StIdle, StWr, StRd} state_e;

  state_e      state_q, state_d;
  logic [9:0]  line_q, line_d;
  logic [4:0]  beat_q, beat_d;
  logic        rd_valid_q, rd_valid_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        accept;
  logic        bank_hit;
  logic        last_beat;

  assign accept    = req_valid && req_ready;
  assign bank_hit  = (req_addr[18:15] == BANK_ID);
  assign last_beat = (beat_q == 5'd0);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      line_q     <= '0;
      beat_q     <= '0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      line_q     <= line_d;
      beat_q     <= beat_d;
      rd_valid_q <= rd_valid_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    line_d     = line_q;
    beat_d     = beat_q;
    rd_valid_d = (state_q == StRd);
    done_d     = 1'b0;
    err_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (bank_hit) begin
            line_d  = req_addr[14:5];
            beat_d  = req_len;
            state_d = req_write ? StWr : StRd;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StWr: begin
        if (wr_valid) begin
          // Line counter is 10 bits wide, so it wraps inside the bank by construction
          line_d = line_q + 10'd1;
          beat_d = beat_q - 5'd1;
          if (last_beat) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
      StRd: begin
        line_d = line_q + 10'd1;
        beat_d = beat_q - 5'd1;
        if (last_beat) begin
          state_d = StIdle;
          // Registered alongside the last rd_valid, so both pulse together
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    req_ready  = rst_n && (state_q == StIdle);
    wr_ready   = (state_q == StWr);
    sram_write = (state_q == StWr) && wr_valid;
    sram_read  = (state_q == StRd);
    sram_cs    = sram_read | sram_write;
    sram_wdata = (state_q == StWr) ? wr_data : '0;
    // Address and id are held at zero while reset is asserted
    sram_addr  = rst_n ? {BANK_ID, line_q, 5'b0} : '0;
    sram_id    = rst_n ? BANK_ID : '0;
    rd_valid   = rd_valid_q;
    rd_data    = rd_valid_q ? sram_rdata : '0;
    done       = done_q;
    err        = err_q;
  end

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Scoreboard bench for mem_burst_ctrl: stimulus pushes expected sram accesses, read beats and
// status pulses into queues; a negedge monitor pops and compares them as the DUT produces them.
module tb_mem_burst_ctrl;

  localparam logic [3:0] BANK = 4'd3;

  logic         clk, rst_n;
  logic         req_valid, req_ready, req_write;
  logic [18:0]  req_addr;
  logic [4:0]   req_len;
  logic [255:0] wr_data, rd_data, sram_wdata, sram_rdata;
  logic         wr_valid, wr_ready, rd_valid, done, err;
  logic         sram_cs, sram_read, sram_write;
  logic [18:0]  sram_addr;
  logic [3:0]   sram_id;

  mem_burst_ctrl #(.BANK_ID(BANK)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .err(err),
    .sram_cs(sram_cs), .sram_read(sram_read), .sram_write(sram_write),
    .sram_addr(sram_addr), .sram_id(sram_id), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic         wr;
    logic [18:0]  addr;
    logic [255:0] data;
  } acc_t;

  typedef struct packed {
    logic [255:0] data;
    logic         last;
  } rd_t;

  acc_t         acc_q[$];
  rd_t          rd_q[$];
  bit           done_q[$];   // 1 = write burst, 0 = read burst
  bit           err_q[$];
  logic [255:0] ref_mem [1024];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic outs_any();
    return |{req_ready, wr_ready, rd_data, rd_valid, done, err, sram_cs, sram_read,
             sram_write, sram_addr, sram_id, sram_wdata};
  endfunction

  // Memory model with one-cycle read latency
  logic [255:0] sram_mem [1024];
  initial begin
    for (int i = 0; i < 1024; i++) sram_mem[i] <= '0;
    sram_rdata <= '0;
    forever begin
      @(posedge clk);
      if (sram_read)  sram_rdata <= sram_mem[sram_addr[14:5]];
      if (sram_write) sram_mem[sram_addr[14:5]] <= sram_wdata;
    end
  end

  // Monitor
  int cyc = 0;
  int last_acc_cyc = -10;
  int last_wr_cyc = -10;
  bit prev_read = 1'b0;
  initial begin
    acc_t a;
    rd_t  r;
    bit   k;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        prev_read = 1'b0;
      end else begin
        chk("cs_is_or", 256'(sram_cs), 256'(sram_read | sram_write));
        chk("rw_exclusive", 256'(sram_read & sram_write), 256'(0));
        chk("sram_id", 256'(sram_id), 256'(BANK));
        chk("rd_valid_latency", 256'(rd_valid), 256'(prev_read));
        if (req_valid && req_ready) last_acc_cyc = cyc;
        if (sram_cs) begin
          if (acc_q.size() == 0) begin
            chk("unexpected_access", 256'(sram_addr), 256'(0));
          end else begin
            a = acc_q.pop_front();
            chk("acc_kind", 256'(sram_write), 256'(a.wr));
            chk("acc_addr", 256'(sram_addr), 256'(a.addr));
            if (a.wr) chk("acc_wdata", sram_wdata, a.data);
          end
          if (sram_write) last_wr_cyc = cyc;
        end
        if (rd_valid) begin
          if (rd_q.size() == 0) begin
            chk("unexpected_rd_valid", 256'(1), 256'(0));
          end else begin
            r = rd_q.pop_front();
            chk("rd_data", rd_data, r.data);
            chk("done_with_last_rd", 256'(done), 256'(r.last));
          end
        end
        if (done) begin
          if (done_q.size() == 0) begin
            chk("unexpected_done", 256'(1), 256'(0));
          end else begin
            k = done_q.pop_front();
            if (k) chk("wr_done_cycle", 256'(cyc), 256'(last_wr_cyc + 1));
            else   chk("rd_done_has_valid", 256'(rd_valid), 256'(1));
          end
        end
        if (err) begin
          if (err_q.size() == 0) begin
            chk("unexpected_err", 256'(1), 256'(0));
          end else begin
            k = err_q.pop_front();
            chk("err_cycle", 256'(cyc), 256'(last_acc_cyc + 1));
          end
        end
        prev_read = sram_read;
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (!req_ready && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 300) chk("idle_timeout", 256'(1), 256'(0));
  endtask

  // Issues one burst; vmode 0 = wr_valid always 1, 1 = toggling 1,0, 2 = random.
  // stop_after >= 0 resets the DUT once that many write beats have been taken.
  task automatic issue(input bit wr, input logic [3:0] bank, input logic [9:0] line,
                       input logic [4:0] len, input int vmode, input int stop_after,
                       output int cycles);
    logic [255:0] beats_d[$];
    logic [255:0] d;
    logic [9:0]   ln;
    acc_t         a;
    rd_t          r;
    int           beats;
    bit           v, hs;
    cycles = 0;
    wait_idle();
    if (bank != BANK) begin
      err_q.push_back(1'b1);
      req_valid = 1'b1; req_write = wr; req_len = len;
      req_addr  = {bank, line, 5'($urandom)};
      @(posedge clk); #1;
      req_valid = 1'b0;
      wr_valid  = 1'b1;
      wr_data   = rand256();
      repeat (3) begin
        chk("err_wr_ready", 256'(wr_ready), 256'(0));
        @(posedge clk); #1;
      end
      wr_valid = 1'b0;
      return;
    end
    for (int i = 0; i <= int'(len); i++) begin
      ln = line + 10'(i);
      a.wr = wr; a.addr = {BANK, ln, 5'b0}; a.data = '0;
      if (wr) begin
        d = rand256();
        beats_d.push_back(d);
        if (stop_after < 0 || i < stop_after) begin
          a.data = d;
          acc_q.push_back(a);
          ref_mem[ln] = d;
        end
      end else begin
        acc_q.push_back(a);
        r.data = ref_mem[ln];
        r.last = (i == int'(len));
        rd_q.push_back(r);
      end
    end
    if (stop_after < 0) done_q.push_back(wr);
    req_valid = 1'b1; req_write = wr; req_len = len;
    req_addr  = {bank, line, 5'($urandom)};
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (!wr) return;
    beats = 0;
    while (beats <= int'(len) && cycles < 400) begin
      if (stop_after >= 0 && beats == stop_after) break;
      case (vmode)
        0:       v = 1'b1;
        1:       v = (cycles % 2 == 0);
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      wr_valid = v;
      wr_data  = v ? beats_d[beats] : rand256();
      hs       = v && wr_ready;
      @(posedge clk); #1;
      cycles++;
      if (hs) beats++;
    end
    if (cycles >= 400) chk("write_timeout", 256'(1), 256'(0));
    if (stop_after >= 0) begin
      rst_n    = 1'b0;
      wr_valid = 1'b0;
      #1;
      chk("midburst_reset_outputs", 256'(outs_any()), 256'(0));
      acc_q.delete(); rd_q.delete(); done_q.delete(); err_q.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
    end else begin
      wr_valid = 1'b0;
    end
  endtask

  initial begin
    int c;
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0;
    wr_data = '0; wr_valid = 1'b0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
    #3;
    chk("reset_outputs", 256'(outs_any()), 256'(0));
    chk("reset_req_ready", 256'(req_ready), 256'(0));
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("ready_after_reset", 256'(req_ready), 256'(1));
    @(posedge clk); #1;

    issue(1'b1, BANK, 10'd2, 5'd3, 0, -1, c);          // write lines 2..5
    issue(1'b0, BANK, 10'd2, 5'd3, 0, -1, c);          // read them back
    issue(1'b1, BANK, 10'd1022, 5'd3, 2, -1, c);       // wrapping write
    issue(1'b0, BANK, 10'd1022, 5'd3, 0, -1, c);       // wrapping read 1022,1023,0,1
    issue(1'b1, 4'd5, 10'd10, 5'd2, 0, -1, c);         // wrong bank
    issue(1'b1, BANK, 10'd100, 5'd7, 1, -1, c);        // toggling wr_valid
    chk("toggle_cycles", 256'(c), 256'(15));
    issue(1'b1, BANK, 10'd200, 5'd7, 0, 3, c);         // reset after three beats
    issue(1'b0, BANK, 10'd100, 5'd7, 0, -1, c);
    issue(1'b0, BANK, 10'd199, 5'd5, 0, -1, c);        // includes partially written lines
    issue(1'b1, BANK, 10'd1023, 5'd0, 0, -1, c);       // single-line bursts
    issue(1'b0, BANK, 10'd1023, 5'd0, 0, -1, c);
    issue(1'b0, 4'd0, 10'd1, 5'd0, 0, -1, c);

    for (int n = 0; n < 30; n++) begin
      logic [3:0] bk;
      bk = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(4, 15)) : BANK;
      issue(1'($urandom_range(0, 1)), bk, 10'($urandom), 5'($urandom), 2, -1, c);
    end

    wait_idle();
    repeat (4) @(posedge clk);
    #1;
    chk("acc_queue_drained", 256'(acc_q.size()), 256'(0));
    chk("rd_queue_drained", 256'(rd_q.size()), 256'(0));
    chk("done_queue_drained", 256'(done_q.size()), 256'(0));
    chk("err_queue_drained", 256'(err_q.size()), 256'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
